lifebar_controller: RTL and testbench
=====================================

Name: lifebar_controller

Overview:
- Owns the player's life state and turns it into lifebar pixels.
- Tracks life count and applies hit and heal events, with a post-hit invulnerability window and a game-over state.
- Colours each pixel reported inside the lifebar rectangle as filled, empty or blinking.
- Sits between the game-logic event pulses and the VGA object mux, downstream of the lifebar rectangle/offset generator.

Parameters:
- MAX_LIFE, 5, life count after reset/newGame; maximum reachable by heal (1..15).
- SEG_WIDTH, 20, pixels of bar per life unit; MAX_LIFE*SEG_WIDTH must be ≤ 2047.
- INVULN_FRAMES, 60, frames of hit immunity after a non-fatal hit (1..255).
- BLINK_FRAMES, 8, frames per blink half-period (1..255).
- LOW_LIFE, 1, at or below this life the filled colour is LOW_COLOR.
- FILL_COLOR, 8'h1C, RGB332 filled colour.
- LOW_COLOR, 8'hE0, RGB332 filled colour at low life.
- EMPTY_COLOR, 8'h49, RGB332 colour of the unfilled portion.

Ports:
- clk, in, 1, system/pixel clock.
- reset, in, 1, synchronous active-high reset.
- startOfFrame, in, 1, one-cycle pulse per frame.
- hitPulse, in, 1, one-cycle damage event.
- healPulse, in, 1, one-cycle +1 life event.
- newGame, in, 1, one-cycle restart request.
- insideRectangle, in, 1, current pixel is inside the lifebar bracket.
- offsetX, in, 11, x offset of the pixel from the bar's left edge.
- lifeCount, out, 4, current life.
- invulnerable, out, 1, high while in INVULN.
- gameOver, out, 1, high while in DEAD.
- drawingRequest, out, 1, registered lifebar draw request.
- RGBout, out, 8, registered pixel colour.

Behaviour:
- Clock and reset:
  - All state updates on rising edge of clk. Reset is synchronous, active-high, and overrides everything.
  - Reset values: lifeCount=MAX_LIFE, state=ALIVE, invulnCnt=0, blinkCnt=0, blinkPhase=0, fillWidth=MAX_LIFE*SEG_WIDTH, invulnerable=0, gameOver=0, drawingRequest=0, RGBout=0.
- Event priority within a cycle: reset > newGame > hitPulse > healPulse.
  - newGame: same state effect as reset, but the pixel path keeps running.
  - hitPulse and healPulse in the same cycle: the hit applies, the heal is dropped.
- State machine:
  - ALIVE + hit: lifeCount-1. If the result is 0, go to DEAD. Otherwise go to INVULN with invulnCnt=INVULN_FRAMES and blinkCnt=0.
  - ALIVE + heal: lifeCount+1, saturating at MAX_LIFE.
  - INVULN: hits are ignored and heals are accepted as in ALIVE. On each startOfFrame, invulnCnt decrements. When startOfFrame arrives with invulnCnt==1, go to ALIVE.
  - DEAD: hits and heals are ignored; lifeCount stays 0; gameOver=1. Only newGame or reset exits.
  - invulnerable = (state==INVULN); gameOver = (state==DEAD). Both are registered, valid the cycle after the transition.
- Blink:
  - In INVULN, or when 0<lifeCount≤LOW_LIFE, blinkCnt counts startOfFrame pulses. On reaching BLINK_FRAMES it resets to 0 and toggles blinkPhase.
  - Outside those conditions, blinkCnt=0 and blinkPhase=0.
- Fill width:
  - fillWidth = lifeCount*SEG_WIDTH, computed at 11-bit width with no overflow.
  - fillWidth is latched only on startOfFrame, using the lifeCount value registered in that cycle. This prevents tearing mid-frame.
- Pixel path (1-cycle latency):
  - drawingRequest <= insideRectangle.
  - If insideRectangle is 0, RGBout <= 0.
  - Else if offsetX < fillWidth and blinkPhase==0: RGBout <= (lifeCount≤LOW_LIFE ? LOW_COLOR : FILL_COLOR).
  - Otherwise RGBout <= EMPTY_COLOR.
  - offsetX is treated as unsigned.
- Counters saturate and never wrap.
  - lifeCount never goes below 0 or above MAX_LIFE.
  - invulnCnt never goes below 0.
- The pixel path ignores startOfFrame timing; it depends only on the latched fillWidth and blinkPhase.

Test Plan:
- Reset, then one frame with insideRectangle=1 and offsetX sweeping 0..99 → lifeCount=5; drawingRequest follows insideRectangle one cycle later; RGBout=8'h1C for offsetX 0..99.
- One hitPulse → lifeCount=4 next cycle and invulnerable=1. After the next startOfFrame, fillWidth=80: offsetX 79 gives 8'h1C (blinkPhase 0), offsetX 80 gives 8'h49. invulnerable falls after exactly 60 startOfFrame pulses. blinkPhase toggles every 8 frames.
- Second hitPulse 10 frames into INVULN → lifeCount stays 4. After the window expires, 4 hits separated by >60 frames → lifeCount=0, gameOver=1. Further hits and heals leave lifeCount=0.
- hitPulse and healPulse in the same cycle from ALIVE with life=3 → lifeCount=2 and INVULN entered. healPulse at life=5 → stays 5.
- At life=1, bar pixels at offsetX<20 alternate between 8'hE0 and 8'h49 every 8 frames.
- newGame from DEAD → life=5 and ALIVE. Reset asserted mid-INVULN with insideRectangle=1 → next cycle drawingRequest=0, RGBout=0, invulnerable=0, lifeCount=5.

Source files
------------

// File: rtl/lifebar_controller.sv
// ---------------------------------------------------------------------------
// lifebar_controller
//
// Owns the player's life state (life count, post-hit invulnerability window,
// game over) and turns it into lifebar pixels for the VGA object mux.
//
// Ports:
//   clk             system / pixel clock
//   reset           synchronous active-high reset, overrides everything
//   startOfFrame    one-cycle pulse per frame
//   hitPulse        one-cycle damage event
//   healPulse       one-cycle +1 life event
//   newGame         one-cycle restart request (state only, pixel path runs on)
//   insideRectangle current pixel lies inside the lifebar bracket
//   offsetX         unsigned x offset of the pixel from the bar's left edge
//   lifeCount       current life
//   invulnerable    high while in the post-hit immunity window
//   gameOver        high while dead
//   drawingRequest  registered draw request (1-cycle latency)
//   RGBout          registered RGB332 pixel colour (1-cycle latency)
// ---------------------------------------------------------------------------
module lifebar_controller #(
    parameter int             MAX_LIFE      = 5,
    parameter int             SEG_WIDTH     = 20,
    parameter int             INVULN_FRAMES = 60,
    parameter int             BLINK_FRAMES  = 8,
    parameter int             LOW_LIFE      = 1,
    parameter logic [7:0]     FILL_COLOR    = 8'h1C,
    parameter logic [7:0]     LOW_COLOR     = 8'hE0,
    parameter logic [7:0]     EMPTY_COLOR   = 8'h49
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        hitPulse,
    input  logic        healPulse,
    input  logic        newGame,
    input  logic        insideRectangle,
    input  logic [10:0] offsetX,
    output logic [3:0]  lifeCount,
    output logic        invulnerable,
    output logic        gameOver,
    output logic        drawingRequest,
    output logic [7:0]  RGBout
);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    localparam logic [3:0]  MAX_LIFE_V   = 4'(MAX_LIFE);
    localparam logic [3:0]  LOW_LIFE_V   = 4'(LOW_LIFE);
    localparam logic [7:0]  INVULN_V     = 8'(INVULN_FRAMES);
    localparam logic [7:0]  BLINK_LAST   = 8'(BLINK_FRAMES - 1);
    localparam logic [10:0] FULL_FILL    = 11'(MAX_LIFE * SEG_WIDTH);

    state_t      state, state_next;
    logic [3:0]  life_next;
    logic [7:0]  invuln_cnt, invuln_next;
    logic [7:0]  blink_cnt, blink_cnt_next;
    logic        blink_phase, blink_phase_next;
    logic [10:0] fill_width, fill_width_next;
    logic        hit_taken;
    logic        blink_active;
    logic        low_life;

    assign low_life     = (lifeCount <= LOW_LIFE_V);
    assign blink_active = (state == INVULN) || ((lifeCount != 4'd0) && low_life);

    // Next-state logic: life, invulnerability window, blink and fill width.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next       = state;
        life_next        = lifeCount;
        invuln_next      = invuln_cnt;
        blink_cnt_next   = blink_cnt;
        blink_phase_next = blink_phase;
        fill_width_next  = fill_width;
        hit_taken        = 1'b0;

        unique case (state)
            ALIVE: begin
                // A hit outranks a heal in the same cycle; the heal is dropped.
                if (hitPulse) begin
                    hit_taken = 1'b1;
                    if (lifeCount <= 4'd1) begin
                        life_next  = 4'd0;
                        state_next = DEAD;
                    end else begin
                        life_next   = lifeCount - 4'd1;
                        state_next  = INVULN;
                        invuln_next = INVULN_V;
                    end
                end else if (healPulse && (lifeCount < MAX_LIFE_V)) begin
                    life_next = lifeCount + 4'd1;
                end
            end
            INVULN: begin
                // Hits are ignored here, so a coincident heal still lands.
                if (healPulse && (lifeCount < MAX_LIFE_V)) begin
                    life_next = lifeCount + 4'd1;
                end
                if (startOfFrame) begin
                    if (invuln_cnt <= 8'd1) begin
                        invuln_next = 8'd0;
                        state_next  = ALIVE;
                    end else begin
                        invuln_next = invuln_cnt - 8'd1;
                    end
                end
            end
            DEAD: begin
                life_next = 4'd0;
            end
            default: begin
                state_next = ALIVE;
            end
        endcase

        // Blink runs off frame pulses only while invulnerable or at low life.
        if (!blink_active) begin
            blink_cnt_next   = 8'd0;
            blink_phase_next = 1'b0;
        end else if (startOfFrame) begin
            if (blink_cnt >= BLINK_LAST) begin
                blink_cnt_next   = 8'd0;
                blink_phase_next = ~blink_phase;
            end else begin
                blink_cnt_next = blink_cnt + 8'd1;
            end
        end
        if (hit_taken) begin
            blink_cnt_next = 8'd0;
        end

        // Fill width only moves at frame start so the bar never tears mid-frame.
        if (startOfFrame) begin
            fill_width_next = 11'(lifeCount) * 11'(SEG_WIDTH);
        end

        if (newGame) begin
            state_next       = ALIVE;
            life_next        = MAX_LIFE_V;
            invuln_next      = 8'd0;
            blink_cnt_next   = 8'd0;
            blink_phase_next = 1'b0;
            fill_width_next  = FULL_FILL;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (reset) begin
            state        <= ALIVE;
            lifeCount    <= MAX_LIFE_V;
            invuln_cnt   <= 8'd0;
            blink_cnt    <= 8'd0;
            blink_phase  <= 1'b0;
            fill_width   <= FULL_FILL;
            invulnerable <= 1'b0;
            gameOver     <= 1'b0;
        end else begin
            state        <= state_next;
            lifeCount    <= life_next;
            invuln_cnt   <= invuln_next;
            blink_cnt    <= blink_cnt_next;
            blink_phase  <= blink_phase_next;
            fill_width   <= fill_width_next;
            invulnerable <= (state_next == INVULN);
            gameOver     <= (state_next == DEAD);
        end
    end

    // Pixel path: one cycle of latency, driven by latched fill width and phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            drawingRequest <= 1'b0;
            RGBout         <= 8'h00;
        end else begin
            drawingRequest <= insideRectangle;
            if (!insideRectangle) begin
                RGBout <= 8'h00;
            end else if ((offsetX < fill_width) && !blink_phase) begin
                RGBout <= low_life ? LOW_COLOR : FILL_COLOR;
            end else begin
                RGBout <= EMPTY_COLOR;
            end
        end
    end

endmodule

// File: tb/tb_lifebar_controller.sv
// ---------------------------------------------------------------------------
// tb_lifebar_controller
//
// Self-checking bench for lifebar_controller. A behavioural model built from
// plain integers (life, frames of immunity left, blink frame count, latched
// fill width) predicts every output each cycle; directed scenarios add
// checks against fixed expected constants, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_lifebar_controller;

    localparam int MAX_LIFE      = 5;
    localparam int SEG_WIDTH     = 20;
    localparam int INVULN_FRAMES = 60;
    localparam int BLINK_FRAMES  = 8;
    localparam int LOW_LIFE      = 1;
    localparam int FILL_C        = 'h1C;
    localparam int LOW_C         = 'hE0;
    localparam int EMPTY_C       = 'h49;
    localparam int FRAME_LEN     = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sof = 1'b0;
    logic        hit = 1'b0;
    logic        heal = 1'b0;
    logic        ng = 1'b0;
    logic        ins = 1'b0;
    logic [10:0] ox = '0;
    logic [3:0]  life;
    logic        inv;
    logic        go;
    logic        dr;
    logic [7:0]  rgb;

    int total = 0;
    int bad   = 0;

    // Model state.
    int m_life, m_left, m_bcnt, m_phase, m_fill, m_dr, m_rgb;

    lifebar_controller #(
        .MAX_LIFE      (MAX_LIFE),
        .SEG_WIDTH     (SEG_WIDTH),
        .INVULN_FRAMES (INVULN_FRAMES),
        .BLINK_FRAMES  (BLINK_FRAMES),
        .LOW_LIFE      (LOW_LIFE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (sof),
        .hitPulse        (hit),
        .healPulse       (heal),
        .newGame         (ng),
        .insideRectangle (ins),
        .offsetX         (ox),
        .lifeCount       (life),
        .invulnerable    (inv),
        .gameOver        (go),
        .drawingRequest  (dr),
        .RGBout          (rgb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_restart();
        m_life  = MAX_LIFE;
        m_left  = 0;
        m_bcnt  = 0;
        m_phase = 0;
        m_fill  = MAX_LIFE * SEG_WIDTH;
    endtask

    // One clock of the game rules, applied to the pre-edge model values.
    task automatic model_step(input bit s, input bit h, input bit he, input bit n,
                              input bit r, input bit in_rect, input int x);
        int  o_life, o_left, o_phase, o_fill;
        bit  blinking;
        o_life  = m_life;
        o_left  = m_left;
        o_phase = m_phase;
        o_fill  = m_fill;
        if (r) begin
            m_dr  = 0;
            m_rgb = 0;
            model_restart();
            return;
        end
        m_dr = in_rect;
        if (!in_rect)                         m_rgb = 0;
        else if (x < o_fill && o_phase == 0)  m_rgb = (o_life <= LOW_LIFE) ? LOW_C : FILL_C;
        else                                  m_rgb = EMPTY_C;
        if (n) begin
            model_restart();
            return;
        end
        blinking = (o_left > 0) || (o_life > 0 && o_life <= LOW_LIFE);
        if (!blinking) begin
            m_bcnt  = 0;
            m_phase = 0;
        end else if (s) begin
            m_bcnt++;
            if (m_bcnt == BLINK_FRAMES) begin
                m_bcnt  = 0;
                m_phase = 1 - m_phase;
            end
        end
        if (s) m_fill = o_life * SEG_WIDTH;
        if (o_life == 0) begin
            // dead: nothing changes until a restart
        end else if (o_left == 0 && h) begin
            m_life = o_life - 1;
            if (m_life > 0) begin
                m_left = INVULN_FRAMES;
                m_bcnt = 0;
            end
        end else begin
            if (he && o_life < MAX_LIFE) m_life = o_life + 1;
            if (o_left > 0 && s) m_left = o_left - 1;
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare all outputs.
    task automatic cycle(input bit s, input bit h, input bit he, input bit n,
                         input bit r, input bit in_rect, input int x);
        sof   = s;
        hit   = h;
        heal  = he;
        ng    = n;
        reset = r;
        ins   = in_rect;
        ox    = 11'(x);
        @(posedge clk);
        model_step(s, h, he, n, r, in_rect, x);
        #1;
        check("life",   int'(life), m_life);
        check("invuln", int'(inv),  (m_left > 0) ? 1 : 0);
        check("gover",  int'(go),   (m_life == 0) ? 1 : 0);
        check("drawreq", int'(dr),  m_dr);
        check("rgb",    int'(rgb),  m_rgb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1, 0, 0, 0, 0, 0, 0);
            idle(FRAME_LEN - 1);
        end
    endtask

    initial begin
        int  n;
        bit  seen_low, seen_empty;
        int  frame_left;

        model_restart();
        m_dr  = 0;
        m_rgb = 0;

        // Reset and reset-state checks.
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 1, 3);
        check("rst_life", int'(life), 5);
        check("rst_dr",   int'(dr),   0);
        check("rst_rgb",  int'(rgb),  0);
        check("rst_inv",  int'(inv),  0);
        check("rst_go",   int'(go),   0);

        // Full bar sweep.
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int x = 0; x < 100; x++) begin
            cycle(0, 0, 0, 0, 0, 1, x);
            check("sweep_rgb", int'(rgb), 'h1C);
            check("sweep_dr",  int'(dr),  1);
        end
        cycle(0, 0, 0, 0, 0, 1, 100);
        check("past_bar", int'(rgb), 'h49);
        cycle(0, 0, 0, 0, 0, 0, 5);
        check("outside", int'(rgb), 0);

        // Heal at full life saturates.
        cycle(0, 0, 1, 0, 0, 0, 0);
        check("heal_sat", int'(life), 5);

        // First hit, fill boundary and invulnerability window length.
        cycle(0, 1, 0, 0, 0, 0, 0);
        check("hit1_life", int'(life), 4);
        check("hit1_inv",  int'(inv),  1);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 79);
        check("fill79", int'(rgb), 'h1C);
        cycle(0, 0, 0, 0, 0, 1, 80);
        check("fill80", int'(rgb), 'h49);
        idle(FRAME_LEN - 3);
        n = 1;
        while (inv && n < 100) begin
            if (n == 10) begin
                cycle(0, 1, 0, 0, 0, 0, 0);
                check("hit_immune", int'(life), 4);
            end
            frames(1);
            n++;
        end
        check("invuln_frames", n, 60);

        // Walk down to death, including a hit+heal collision at life 3.
        cycle(0, 1, 0, 0, 0, 0, 0);
        check("hit2_life", int'(life), 3);
        frames(70);
        cycle(0, 1, 1, 0, 0, 0, 0);
        check("hitheal_life", int'(life), 2);
        check("hitheal_inv",  int'(inv),  1);
        frames(70);
        cycle(0, 1, 0, 0, 0, 0, 0);
        check("hit3_life", int'(life), 1);
        frames(70);
        check("low_alive", int'(inv), 0);

        // Low-life blink: bar pixel alternates between low colour and empty.
        seen_low   = 0;
        seen_empty = 0;
        for (int f = 0; f < 32; f++) begin
            cycle(1, 0, 0, 0, 0, 0, 0);
            cycle(0, 0, 0, 0, 0, 1, 5);
            if (rgb == 8'hE0) seen_low = 1;
            if (rgb == 8'h49) seen_empty = 1;
            idle(FRAME_LEN - 2);
        end
        check("blink_low",   int'(seen_low),   1);
        check("blink_empty", int'(seen_empty), 1);

        cycle(0, 1, 0, 0, 0, 0, 0);
        check("dead_life", int'(life), 0);
        check("dead_go",   int'(go),   1);
        for (int i = 0; i < 20; i++) cycle(i % 3 == 0, i % 2, i % 2 == 0, 0, 0, 1, i);
        check("dead_stays", int'(life), 0);

        // Restart from death.
        cycle(0, 0, 0, 1, 0, 0, 0);
        check("ng_life", int'(life), 5);
        check("ng_go",   int'(go),   0);
        check("ng_inv",  int'(inv),  0);

        // Reset in the middle of invulnerability while drawing.
        cycle(0, 1, 0, 0, 0, 0, 0);
        frames(3);
        cycle(0, 0, 0, 0, 0, 1, 2);
        cycle(0, 0, 0, 0, 1, 1, 2);
        check("rst_mid_dr",   int'(dr),   0);
        check("rst_mid_rgb",  int'(rgb),  0);
        check("rst_mid_inv",  int'(inv),  0);
        check("rst_mid_life", int'(life), 5);

        // Randomized traffic against the model.
        frame_left = 0;
        for (int i = 0; i < 15000; i++) begin
            bit s;
            s = (frame_left == 0);
            if (s) frame_left = $urandom_range(14, 4);
            else   frame_left--;
            cycle(s,
                  ($urandom % 60)   == 0,
                  ($urandom % 50)   == 0,
                  ($urandom % 2500) == 0,
                  ($urandom % 4000) == 0,
                  $urandom_range(1, 0) == 1,
                  $urandom_range(127, 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
